aes128_keysched_ark: RTL and testbench
======================================

Name: aes128_keysched_ark

Overview:
- Clocked AES-128 helper block for the encryption datapath.
- Expands a 128-bit cipher key into the 11 round keys (FIPS-197 key schedule).
- Performs the linear per-round step: optional ShiftRows on a state, then AddRoundKey with a selected round key.
- Feeds the iterative cipher controller, which supplies SubBytes/MixColumns elsewhere.

Parameters:
- NR, 10, number of rounds; fixed for AES-128; round-key bus width is 128*(NR+1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- key_load  in  1  capture key_in and expand it.
- key_in  in  128  cipher key; bits [127:120] are key byte 0.
- round_keys  out  1408  registered schedule; round r key at [1407-128*r -: 128].
- keys_valid  out  1  round_keys holds a fully expanded key.
- in_valid  in  1  state_in, round_idx and shift_en are valid this cycle.
- state_in  in  128  AES state, column-major; byte 0 = [127:120] = s(0,0), byte 1 = s(1,0), and so on.
- round_idx  in  4  round key select, 0..10.
- shift_en  in  1  1 = apply ShiftRows before AddRoundKey.
- state_out  out  128  registered result.
- out_valid  out  1  state_out is updated this cycle.

Behaviour:
- Reset (rst=1 at a clk edge) clears round_keys, state_out, keys_valid and out_valid to 0. Reset overrides key_load and in_valid in the same cycle.
- Key expansion:
  - w0..w3 = key_in[127:96], [95:64], [63:32], [31:0].
  - For i=4..43: w[i] = w[i-4] ^ t.
  - t = SubWord(RotWord(w[i-1])) ^ {Rcon[i/4],24'h0} when i%4==0; otherwise t = w[i-1].
  - RotWord rotates one byte left: {b1,b2,b3,b0}.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
  - SubWord applies the FIPS-197 S-box to each byte.
  - Round key r = {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
- Key timing:
  - key_load=1 at edge N: round_keys holds expand(key_in) and keys_valid=1 from edge N onward. Latency is 1 cycle.
  - Expansion is combinational from key_in into the register.
  - round_keys holds its value until the next key_load or reset.
- ShiftRows: row r is rotated left by r bytes. Output byte order is {b0,b5,b10,b15, b4,b9,b14,b3, b8,b13,b2,b7, b12,b1,b6,b11}.
- Datapath, when in_valid=1 at an edge:
  - state_out <= (shift_en ? ShiftRows(state_in) : state_in) ^ round_keys[round_idx].
  - out_valid <= 1.
- When in_valid=0 at an edge: out_valid <= 0 and state_out holds its value.
- round_idx greater than 10 saturates to 10.
- key_load and in_valid in the same cycle: the datapath uses the round_keys register value from before that edge (the old keys).
- in_valid while keys_valid=0: the operation proceeds with the current (zero) keys, and out_valid still asserts.
- Full throughput: one datapath operation per cycle, with no backpressure.

Decomposition:
- Shared package aes_pkg holds:
  - S-box function sbox(byte);
  - Rcon constant array;
  - AES_STATE_W=128 and RK_W=1408 constants;
  - shift_rows function;
  - round-key slice helper.
- One sub-module, aes128_key_expand: a purely combinational key → 1408-bit schedule. The top registers its output.
- ShiftRows and AddRoundKey are implemented inline in the top.

Test Plan:
- Reset: assert rst with key_load=1 and in_valid=1 → next cycle round_keys=0, state_out=0, keys_valid=0, out_valid=0.
- Key 2b7e151628aed2a6abf7158809cf4f3c, key_load 1 cycle → next cycle:
  - round 0 key = same value;
  - round 1 key = a0fafe1788542cb123a339392a6c7605;
  - round 10 key = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - keys_valid=1.
- Key 000102030405060708090a0b0c0d0e0f → round 10 key = 13111d7fe3944a17f307a78b4d2b30c5.
- With the 2b7e… key loaded: in_valid, shift_en=0, round_idx=0, state 3243f6a8885a308d313198a2e0370734 → next cycle state_out=193de3bea0f4e22b9ac68d2ae9f84808, out_valid=1.
- Same key: shift_en=1, round_idx=0, state 000102030405060708090a0b0c0d0e0f → state_out=2b7b1f192ca7dca5a3fa178f05ce4937.
- Boundaries:
  - round_idx=15 gives the same result as round_idx=10.
  - key_load and in_valid together use the old keys.
  - in_valid deasserted → out_valid=0 and state_out held.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: widths, S-box, Rcon, ShiftRows and the round-key slice helper.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int NR_ROUNDS   = 10;
  localparam int RK_W        = 128 * (NR_ROUNDS + 1);

  // Entry b of the FIPS-197 S-box sits at index b (leftmost literal is index 0).
  localparam logic [0:255][7:0] SBOX_TBL = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[b];
  endfunction

  // Column-major state: out byte 4c+r takes in byte 4*((c+r)%4)+r.
  function automatic logic [AES_STATE_W-1:0] shift_rows(input logic [AES_STATE_W-1:0] s);
    logic [AES_STATE_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  // Round index above the last round saturates to the last round key.
  function automatic logic [AES_STATE_W-1:0] rk_slice(input logic [RK_W-1:0] rks,
                                                      input logic [3:0]      idx);
    logic [3:0] r;
    r = (idx > 4'(NR_ROUNDS)) ? 4'(NR_ROUNDS) : idx;
    return rks[RK_W-1-128*r -: 128];
  endfunction

endpackage

// File: rtl/aes128_keysched_ark_if.sv
// Per-round datapath channel between the cipher controller and the key-schedule/ARK block.
interface aes128_keysched_ark_if;
  // Valid-only stream: in_valid qualifies state_in/round_idx/shift_en for one cycle, there is
  // no ready (the block accepts every cycle); out_valid marks the one cycle state_out is new.
  logic         in_valid;
  logic [127:0] state_in;
  logic [3:0]   round_idx;
  logic         shift_en;
  logic [127:0] state_out;
  logic         out_valid;

  modport master (output in_valid, state_in, round_idx, shift_en,
                  input  state_out, out_valid);
  modport slave  (input  in_valid, state_in, round_idx, shift_en,
                  output state_out, out_valid);
endinterface

// File: rtl/aes128_key_expand.sv
// Combinational AES-128 key expansion: 128-bit cipher key to 11 concatenated round keys.
module aes128_key_expand
  import aes_pkg::*;
(
  input  logic [127:0]    key,
  output logic [RK_W-1:0] sched
);

  function automatic logic [RK_W-1:0] expand(input logic [127:0] k);
    logic [31:0]     w [0:43];
    logic [31:0]     t;
    logic [RK_W-1:0] s;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      if (i % 4 == 0) begin
        // SubWord(RotWord(w[i-1])) with the round constant folded into the top byte.
        t = {sbox(w[i-1][23:16]) ^ RCON[i/4], sbox(w[i-1][15:8]),
             sbox(w[i-1][7:0]), sbox(w[i-1][31:24])};
      end else begin
        t = w[i-1];
      end
      w[i] = w[i-4] ^ t;
    end
    s = '0;
    for (int i = 0; i < 44; i++) s[RK_W-1-32*i -: 32] = w[i];
    return s;
  endfunction

  assign sched = expand(key);

endmodule

// File: rtl/aes128_keysched_ark.sv
// Registered AES-128 key schedule plus the per-round ShiftRows/AddRoundKey step.
module aes128_keysched_ark
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_load,
  input  logic [127:0]            key_in,
  output logic [128*(NR+1)-1:0]   round_keys,
  output logic                    keys_valid,
  aes128_keysched_ark_if.slave    dp
);

  logic [RK_W-1:0]        sched;
  logic [AES_STATE_W-1:0] pre_ark;
  logic [AES_STATE_W-1:0] sel_key;

  aes128_key_expand u_key_expand (
    .key   (key_in),
    .sched (sched)
  );

  // The datapath reads the registered keys, so a same-cycle key_load only affects later ops.
  assign pre_ark = dp.shift_en ? shift_rows(dp.state_in) : dp.state_in;
  assign sel_key = rk_slice(round_keys, dp.round_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      round_keys   <= '0;
      keys_valid   <= 1'b0;
      dp.state_out <= '0;
      dp.out_valid <= 1'b0;
    end else begin
      if (key_load) begin
        round_keys <= sched;
        keys_valid <= 1'b1;
      end
      dp.out_valid <= dp.in_valid;
      if (dp.in_valid) dp.state_out <= pre_ark ^ sel_key;
    end
  end

endmodule

// File: tb/tb_aes128_keysched_ark.sv
// Self-checking bench for aes128_keysched_ark: FIPS-197 vectors, boundaries and random ARK ops.
module tb_aes128_keysched_ark;

  logic          clk;
  logic          rst;
  logic          key_load;
  logic [127:0]  key_in;
  logic [1407:0] round_keys;
  logic          keys_valid;

  aes128_keysched_ark_if dp_if ();

  aes128_keysched_ark dut (
    .clk        (clk),
    .rst        (rst),
    .key_load   (key_load),
    .key_in     (key_in),
    .round_keys (round_keys),
    .keys_valid (keys_valid),
    .dp         (dp_if)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [127:0] exp_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [127:0] rk_tab [0:10];
  logic [127:0] last_exp;

  localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam int SR_MAP [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] sr_model(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = s[127-8*SR_MAP[k] -: 8];
    return r;
  endfunction

  function automatic logic [127:0] rk_of(input logic [1407:0] rks, input int r);
    return rks[1407-128*r -: 128];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    key_load = 1'b1;
    key_in   = k;
    tick();
    key_load = 1'b0;
  endtask

  task automatic drive_op(input logic [127:0] s, input logic [3:0] idx, input logic sh,
                          input logic [127:0] e);
    dp_if.in_valid  = 1'b1;
    dp_if.state_in  = s;
    dp_if.round_idx = idx;
    dp_if.shift_en  = sh;
    exp_q.push_back(e);
    last_exp = e;
    tick();
    dp_if.in_valid = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (dp_if.out_valid === 1'b1) begin
      if (exp_q.size() == 0) check_eq("spurious_out_valid", {127'b0, dp_if.out_valid}, 128'd0);
      else check_eq("ark_out", dp_if.state_out, exp_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] s;
    logic [3:0]   idx;
    logic         sh;
    logic [3:0]   sat;

    rk_tab[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk_tab[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk_tab[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk_tab[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk_tab[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk_tab[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk_tab[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk_tab[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk_tab[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk_tab[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk_tab[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst             = 1'b1;
    key_load        = 1'b0;
    key_in          = '0;
    dp_if.in_valid  = 1'b0;
    dp_if.state_in  = '0;
    dp_if.round_idx = '0;
    dp_if.shift_en  = 1'b0;
    last_exp        = '0;
    tick();
    tick();

    // Reset wins over key_load and in_valid in the same cycle.
    key_load        = 1'b1;
    key_in          = KEY1;
    dp_if.in_valid  = 1'b1;
    dp_if.state_in  = 128'h3243f6a8885a308d313198a2e0370734;
    tick();
    for (int r = 0; r <= 10; r++) check_eq($sformatf("rst_rk%0d", r), rk_of(round_keys, r), 128'd0);
    check_eq("rst_keys_valid", {127'b0, keys_valid}, 128'd0);
    check_eq("rst_out_valid", {127'b0, dp_if.out_valid}, 128'd0);
    check_eq("rst_state_out", dp_if.state_out, 128'd0);
    rst            = 1'b0;
    key_load       = 1'b0;
    dp_if.in_valid = 1'b0;
    tick();
    check_eq("idle_keys_valid", {127'b0, keys_valid}, 128'd0);

    // Operation before any key load runs with zero keys.
    s = 128'h3243f6a8885a308d313198a2e0370734;
    drive_op(s, 4'd3, 1'b1, sr_model(s));
    tick();

    load_key(KEY1);
    check_eq("k1_keys_valid", {127'b0, keys_valid}, 128'd1);
    check_eq("k1_rk1_vec", rk_of(round_keys, 1), 128'ha0fafe1788542cb123a339392a6c7605);
    check_eq("k1_rk10_vec", rk_of(round_keys, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    for (int r = 0; r <= 10; r++) check_eq($sformatf("k1_rk%0d", r), rk_of(round_keys, r), rk_tab[r]);

    // FIPS-197 vectors, back to back.
    drive_op(128'h3243f6a8885a308d313198a2e0370734, 4'd0, 1'b0,
             128'h193de3bea0f4e22b9ac68d2ae9f84808);
    drive_op(128'h000102030405060708090a0b0c0d0e0f, 4'd0, 1'b1,
             128'h2b7b1f192ca7dca5a3fa178f05ce4937);

    // Idle cycle: out_valid drops and state_out holds.
    tick();
    check_eq("hold_out_valid", {127'b0, dp_if.out_valid}, 128'd0);
    check_eq("hold_state_out", dp_if.state_out, last_exp);

    // Saturation: idx 15 and idx 10 both select round 10.
    s = 128'h00112233445566778899aabbccddeeff;
    drive_op(s, 4'd15, 1'b0, s ^ rk_tab[10]);
    drive_op(s, 4'd10, 1'b0, s ^ rk_tab[10]);
    drive_op(s, 4'd11, 1'b1, sr_model(s) ^ rk_tab[10]);

    // Same-cycle key_load and in_valid: the op uses the old schedule.
    key_load = 1'b1;
    key_in   = KEY2;
    drive_op(s, 4'd1, 1'b0, s ^ rk_tab[1]);
    key_load = 1'b0;
    check_eq("k2_rk0", rk_of(round_keys, 0), KEY2);
    check_eq("k2_rk10", rk_of(round_keys, 10), KEY2_R10);
    drive_op(s, 4'd10, 1'b0, s ^ KEY2_R10);
    drive_op(s, 4'd0, 1'b1, sr_model(s) ^ KEY2);
    tick();

    // Random ops with random idle gaps under KEY1.
    load_key(KEY1);
    for (int n = 0; n < 40; n++) begin
      s   = {$urandom, $urandom, $urandom, $urandom};
      idx = 4'($urandom_range(0, 15));
      sh  = 1'($urandom_range(0, 1));
      sat = (idx > 4'd10) ? 4'd10 : idx;
      drive_op(s, idx, sh, (sh ? sr_model(s) : s) ^ rk_tab[sat]);
      if ($urandom_range(0, 3) == 0) tick();
    end

    // Drain: everything pushed must have been observed.
    repeat (3) tick();
    check_eq("drain_queue_empty", 128'(exp_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
